md_force_accum: RTL and testbench

Parametrised force-accumulation engine for the MachSuite MD kernel, successor to the single-word force stub. It takes a job of `num_atoms` atoms, streams per-neighbour displacement vectors (dx, dy, dz), and scales each one by a runtime fixed-point coefficient. For each atom it accumulates three force components and emits one force vector through a valid/ready handshake. It sits between the neighbour-list walker (upstream) and the force write-back buffer (downstream).

---
 rtl/md_force_accum.sv | 164 ++++++++++++++++
 tb/tb_md_force_accum.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_force_accum.sv
// Force-accumulation engine: scales streamed neighbour displacements by a fixed-point
// coefficient and emits one accumulated force vector per atom. Define MD_FORCE_SAT_EN for saturating arithmetic.
module md_force_accum #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned ATOM_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ATOM_W-1:0] num_atoms,
  input  logic [DATA_W-1:0] coef,
  input  logic              nbr_valid,
  output logic              nbr_ready,
  input  logic [DATA_W-1:0] nbr_dx,
  input  logic [DATA_W-1:0] nbr_dy,
  input  logic [DATA_W-1:0] nbr_dz,
  input  logic              nbr_last,
  output logic              force_valid,
  input  logic              force_ready,
  output logic [DATA_W-1:0] force_x,
  output logic [DATA_W-1:0] force_y,
  output logic [DATA_W-1:0] force_z,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PROD_W = 2 * DATA_W;

`ifdef MD_FORCE_SAT_EN
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_DRAIN = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ATOM_W-1:0] remaining;
  logic [DATA_W-1:0] coef_q;
  logic              p_valid;
  logic [DATA_W-1:0] p_x;
  logic [DATA_W-1:0] p_y;
  logic [DATA_W-1:0] p_z;
  logic [DATA_W-1:0] acc_x;
  logic [DATA_W-1:0] acc_y;
  logic [DATA_W-1:0] acc_z;
  logic              nbr_hs;
  logic              force_hs;
  logic              job_start;

  assign nbr_hs    = nbr_valid & nbr_ready;
  assign force_hs  = force_valid & force_ready;
  assign job_start = (state == S_IDLE) & start;

  // Full-precision product, floor shift, then reduce back to DATA_W.
  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] d,
                                              input logic [DATA_W-1:0] c);
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    prod    = $signed({{DATA_W{d[DATA_W-1]}}, d}) * $signed({{DATA_W{c[DATA_W-1]}}, c});
    shifted = prod >>> FRAC_W;
`ifdef MD_FORCE_SAT_EN
    if (shifted > SAT_MAX) return DATA_W'(SAT_MAX);
    if (shifted < SAT_MIN) return DATA_W'(SAT_MIN);
`endif
    return DATA_W'(shifted);
  endfunction

  function automatic logic [DATA_W-1:0] accum(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
`ifdef MD_FORCE_SAT_EN
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    // Sign bits disagree only on overflow; the carry-out bit gives its direction.
    if (sum[DATA_W] != sum[DATA_W-1])
      return sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return sum[DATA_W-1:0];
`else
    return a + b;
`endif
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_atoms != '0) ? S_ACCUM : S_DONE;
      S_ACCUM: if (nbr_hs && nbr_last) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_EMIT;
      S_EMIT:  if (force_hs) state_nxt = (remaining == ATOM_W'(1)) ? S_DONE : S_ACCUM;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control: state, handshake flags decoded from the next state, job parameters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      nbr_ready   <= 1'b0;
      force_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      remaining   <= '0;
      coef_q      <= '0;
    end else begin
      state       <= state_nxt;
      nbr_ready   <= (state_nxt == S_ACCUM);
      force_valid <= (state_nxt == S_EMIT);
      busy        <= (state_nxt != S_IDLE);
      done        <= (state_nxt == S_DONE);
      if (job_start) begin
        remaining <= num_atoms;
        coef_q    <= coef;
      end else if (force_hs) begin
        remaining <= remaining - ATOM_W'(1);
      end
    end
  end

  // Datapath: stage-1 scaled products, stage-2 accumulators.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_valid <= 1'b0;
      p_x     <= '0;
      p_y     <= '0;
      p_z     <= '0;
      acc_x   <= '0;
      acc_y   <= '0;
      acc_z   <= '0;
    end else begin
      p_valid <= nbr_hs;
      if (nbr_hs) begin
        p_x <= scale(nbr_dx, coef_q);
        p_y <= scale(nbr_dy, coef_q);
        p_z <= scale(nbr_dz, coef_q);
      end else if (job_start) begin
        p_x <= '0;
        p_y <= '0;
        p_z <= '0;
      end
      if (force_hs || job_start) begin
        acc_x <= '0;
        acc_y <= '0;
        acc_z <= '0;
      end else if (p_valid) begin
        acc_x <= accum(acc_x, p_x);
        acc_y <= accum(acc_y, p_y);
        acc_z <= accum(acc_z, p_z);
      end
    end
  end

  assign force_x = acc_x;
  assign force_y = acc_y;
  assign force_z = acc_z;

endmodule

// File: tb/tb_md_force_accum.sv
// Directed table-driven bench for md_force_accum plus hand-written multi-cycle sequences.
module tb_md_force_accum;

  typedef struct packed {
    logic [31:0]      coef;
    logic [2:0]       n;
    logic [3:0][31:0] dx;
    logic [3:0][31:0] dy;
    logic [3:0][31:0] dz;
    logic [31:0]      ex;
    logic [31:0]      ey;
    logic [31:0]      ez;
  } vec_t;

  localparam int NVEC = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  num_atoms;
  logic [31:0] coef;
  logic        nbr_valid;
  logic        nbr_ready;
  logic [31:0] nbr_dx;
  logic [31:0] nbr_dy;
  logic [31:0] nbr_dz;
  logic        nbr_last;
  logic        force_valid;
  logic        force_ready;
  logic [31:0] force_x;
  logic [31:0] force_y;
  logic [31:0] force_z;
  logic        busy;
  logic        done;

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  vec_t vecs[NVEC];
  vec_t two_ones;

  md_force_accum dut (
    .clk(clk), .reset(reset), .start(start), .num_atoms(num_atoms), .coef(coef),
    .nbr_valid(nbr_valid), .nbr_ready(nbr_ready), .nbr_dx(nbr_dx), .nbr_dy(nbr_dy),
    .nbr_dz(nbr_dz), .nbr_last(nbr_last), .force_valid(force_valid),
    .force_ready(force_ready), .force_x(force_x), .force_y(force_y), .force_z(force_z),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic hd(input int idx, input logic [31:0] c, input logic [31:0] x,
                    input logic [31:0] y, input logic [31:0] z);
    vecs[idx] = '0;
    vecs[idx].coef = c;
    vecs[idx].ex = x;
    vecs[idx].ey = y;
    vecs[idx].ez = z;
  endtask

  task automatic nb(input int idx, input int k, input logic [31:0] x,
                    input logic [31:0] y, input logic [31:0] z);
    vecs[idx].dx[k] = x;
    vecs[idx].dy[k] = y;
    vecs[idx].dz[k] = z;
    vecs[idx].n = 3'(k + 1);
  endtask

  // Start pulse, then scramble the job inputs to prove they were latched.
  task automatic do_start(input logic [9:0] n, input logic [31:0] c);
    start = 1'b1;
    num_atoms = n;
    coef = c;
    @(negedge clk);
    start = 1'b0;
    num_atoms = 10'h3FF;
    coef = 32'h1234_5678;
  endtask

  // Sends every neighbour of one atom; returns at the negedge after the last accept.
  task automatic send_atom(input vec_t v, input string tag);
    for (int i = 0; i < int'(v.n); i++) begin
      int guard;
      guard = 0;
      nbr_valid = 1'b1;
      nbr_dx = v.dx[i];
      nbr_dy = v.dy[i];
      nbr_dz = v.dz[i];
      nbr_last = (i == int'(v.n) - 1);
      while (nbr_ready !== 1'b1 && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      if (nbr_ready !== 1'b1) check({tag, " nbr_ready timeout"}, 32'(nbr_ready), 32'd1);
      @(negedge clk);
    end
    nbr_valid = 1'b0;
    nbr_last = 1'b0;
    nbr_dx = '0;
    nbr_dy = '0;
    nbr_dz = '0;
    check({tag, " drain no valid"}, 32'(force_valid), 32'd0);
    @(negedge clk);
    check({tag, " valid after drain"}, 32'(force_valid), 32'd1);
  endtask

  // Holds force_ready low for `stall` cycles, then takes the force vector.
  task automatic take_force(input vec_t v, input int stall, input bit last, input string tag);
    for (int k = 0; k < stall; k++) begin
      start = 1'b1;
      num_atoms = 10'd0;
      check({tag, " stall x"}, force_x, v.ex);
      check({tag, " stall nbr_ready"}, 32'(nbr_ready), 32'd0);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " valid"}, 32'(force_valid), 32'd1);
    check({tag, " force_x"}, force_x, v.ex);
    check({tag, " force_y"}, force_y, v.ey);
    check({tag, " force_z"}, force_z, v.ez);
    force_ready = 1'b1;
    @(negedge clk);
    force_ready = 1'b0;
    check({tag, " valid drop"}, 32'(force_valid), 32'd0);
    if (last) begin
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " busy in done"}, 32'(busy), 32'd1);
    end else begin
      check({tag, " next nbr_ready"}, 32'(nbr_ready), 32'd1);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int d0;
    d0 = done_cnt;
    do_start(10'd1, v.coef);
    send_atom(v, tag);
    take_force(v, 0, 1'b1, tag);
    @(negedge clk);
    check({tag, " done low"}, 32'(done), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " done count"}, 32'(done_cnt), 32'(d0 + 1));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    num_atoms = '0;
    coef = '0;
    nbr_valid = 1'b0;
    nbr_dx = '0;
    nbr_dy = '0;
    nbr_dz = '0;
    nbr_last = 1'b0;
    force_ready = 1'b0;

    hd(0, 32'd16, 32'd6, 32'd0, 32'd0);
    nb(0, 0, 32'd1, 32'd0, 32'd0);
    nb(0, 1, 32'd2, 32'd0, 32'd0);
    nb(0, 2, 32'd3, 32'd0, 32'd0);
    hd(1, 32'd8, 32'hFFFF_FFFC, 32'd0, 32'd0);
    nb(1, 0, 32'hFFFF_FFFB, 32'd0, 32'd0);
    nb(1, 1, 32'hFFFF_FFFF, 32'd0, 32'd0);
    hd(2, 32'd16, 32'd0, 32'hFFFF_FFF9, 32'd100);
    nb(2, 0, 32'd0, 32'hFFFF_FFF9, 32'd100);
    hd(3, 32'd24, 32'd4, 32'hFFFF_FFFB, 32'd30);
    nb(3, 0, 32'd3, 32'hFFFF_FFFD, 32'd10);
    nb(3, 1, 32'd0, 32'd0, 32'd10);
    hd(4, 32'hFFFF_FFF0, 32'hFFFF_FFFB, 32'd6, 32'hFFFF_FFFF);
    nb(4, 0, 32'd5, 32'hFFFF_FFFA, 32'd1);
`ifdef MD_FORCE_SAT_EN
    hd(5, 32'd32, 32'h7FFF_FFFF, 32'd0, 32'd0);
    hd(7, 32'd32, 32'h8000_0000, 32'd0, 32'd0);
`else
    hd(5, 32'd32, 32'hFFFF_FFFC, 32'd0, 32'd0);
    hd(7, 32'd32, 32'h0000_0000, 32'd0, 32'd0);
`endif
    nb(5, 0, 32'h7FFF_FFFF, 32'd0, 32'd0);
    nb(5, 1, 32'h7FFF_FFFF, 32'd0, 32'd0);
    hd(6, 32'd16, 32'd0, 32'd0, 32'd0);
    nb(6, 0, 32'd0, 32'd0, 32'd0);
    nb(7, 0, 32'h8000_0000, 32'd0, 32'd0);
    nb(7, 1, 32'h8000_0000, 32'd0, 32'd0);
    two_ones = '0;
    two_ones.n = 3'd2;
    two_ones.dx[0] = 32'd1;
    two_ones.dx[1] = 32'd1;
    two_ones.ex = 32'd2;

    repeat (3) @(negedge clk);
    check("reset nbr_ready", 32'(nbr_ready), 32'd0);
    check("reset force_valid", 32'(force_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset force_x", force_x, 32'd0);
    check("reset force_y", force_y, 32'd0);
    check("reset force_z", force_z, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Three atoms, five stalled cycles each, with stray start requests during EMIT.
    begin
      int d0;
      d0 = done_cnt;
      do_start(10'd3, 32'd16);
      for (int a = 0; a < 3; a++) begin
        send_atom(two_ones, $sformatf("multi atom%0d", a));
        take_force(two_ones, 5, a == 2, $sformatf("multi atom%0d", a));
      end
      repeat (3) @(negedge clk);
      check("multi done count", 32'(done_cnt), 32'(d0 + 1));
      check("multi idle busy", 32'(busy), 32'd0);
    end

    // Zero-atom job goes straight to DONE.
    begin
      int d0;
      d0 = done_cnt;
      do_start(10'd0, 32'd16);
      check("zero done", 32'(done), 32'd1);
      check("zero busy", 32'(busy), 32'd1);
      check("zero nbr_ready", 32'(nbr_ready), 32'd0);
      check("zero force_valid", 32'(force_valid), 32'd0);
      @(negedge clk);
      check("zero done low", 32'(done), 32'd0);
      check("zero busy low", 32'(busy), 32'd0);
      check("zero nbr_ready idle", 32'(nbr_ready), 32'd0);
      check("zero done count", 32'(done_cnt), 32'(d0 + 1));
    end

    // Reset after the first neighbour of a two-atom job.
    begin
      int d0;
      d0 = done_cnt;
      do_start(10'd2, 32'd16);
      nbr_valid = 1'b1;
      nbr_dx = 32'd5;
      nbr_last = 1'b0;
      check("rst pre nbr_ready", 32'(nbr_ready), 32'd1);
      @(negedge clk);
      nbr_valid = 1'b0;
      nbr_dx = '0;
      @(negedge clk);
      check("rst pre busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("rst nbr_ready", 32'(nbr_ready), 32'd0);
      check("rst force_valid", 32'(force_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst force_x", force_x, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst idle busy", 32'(busy), 32'd0);
      check("rst no done", 32'(done_cnt), 32'(d0));
      run_vec(vecs[0], "after reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
